// File: rtl/id_ex_operand_latch_if.sv
// Operand-fetch stage bus: decode handshake, register-file read port,
// write-back snoop, and the ID/EX operand register outputs.
interface id_ex_operand_latch_if #(
  parameter int DW   = 16,
  parameter int NREG = 16,
  parameter int CW   = 8
);
  localparam int AW = $clog2(NREG);

  logic            src_valid;
  logic [AW-1:0]   src1_reg;
  logic [AW-1:0]   src2_reg;
  logic            src_ready;
  logic [NREG-1:0] ren1;
  logic [NREG-1:0] ren2;
  logic [DW-1:0]   bitline1;
  logic [DW-1:0]   bitline2;
  logic            wb_we;
  logic [AW-1:0]   wb_reg;
  logic [DW-1:0]   wb_data;
  logic            flush;
  logic            ex_ready;
  logic            op_valid;
  logic [DW-1:0]   op1;
  logic [DW-1:0]   op2;
  logic [AW-1:0]   op_src1;
  logic [AW-1:0]   op_src2;
  logic [CW-1:0]   stall_cnt;

  modport slave (
    input  src_valid, src1_reg, src2_reg, bitline1, bitline2,
           wb_we, wb_reg, wb_data, flush, ex_ready,
    output src_ready, ren1, ren2, op_valid, op1, op2, op_src1, op_src2, stall_cnt
  );

  modport master (
    output src_valid, src1_reg, src2_reg, bitline1, bitline2,
           wb_we, wb_reg, wb_data, flush, ex_ready,
    input  src_ready, ren1, ren2, op_valid, op1, op2, op_src1, op_src2, stall_cnt
  );
endinterface

// File: rtl/id_ex_operand_latch.sv
// ID/EX operand latch: one-hot register-file read enables, write-back bypass
// on capture, and write-back refresh of held operands while EX stalls.
module id_ex_operand_latch #(
  parameter int DW   = 16,
  parameter int NREG = 16,
  parameter int CW   = 8
) (
  input logic                 clk,
  input logic                 rst,
  id_ex_operand_latch_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam logic [CW-1:0] STALL_MAX = {CW{1'b1}};

  // Register 0 reads as zero; a same-edge write-back wins over the stale bitline.
  function automatic logic [DW-1:0] select_operand(
    input logic [AW-1:0] src,
    input logic [DW-1:0] bitline,
    input logic          we,
    input logic [AW-1:0] wreg,
    input logic [DW-1:0] wdata
  );
    logic [DW-1:0] val;
    if (src == {AW{1'b0}}) begin
      val = {DW{1'b0}};
    end else if (we && (wreg == src)) begin
      val = wdata;
    end else begin
      val = bitline;
    end
    return val;
  endfunction

  logic            op_valid_r;
  logic [DW-1:0]   op1_r;
  logic [DW-1:0]   op2_r;
  logic [AW-1:0]   op_src1_r;
  logic [AW-1:0]   op_src2_r;
  logic [CW-1:0]   stall_cnt_r;

  logic            src_ready_s;
  logic            capture_s;
  logic            stalled_s;
  logic            refresh1_s;
  logic            refresh2_s;
  logic [DW-1:0]   sel1_s;
  logic [DW-1:0]   sel2_s;
  logic [NREG-1:0] ren1_s;
  logic [NREG-1:0] ren2_s;

  // Handshake, bypass select, and hold-refresh qualifiers.
  always_comb begin
    src_ready_s = !op_valid_r || bus.ex_ready;
    capture_s   = bus.src_valid && src_ready_s && !bus.flush;
    stalled_s   = op_valid_r && !bus.ex_ready;
    sel1_s      = select_operand(bus.src1_reg, bus.bitline1, bus.wb_we, bus.wb_reg, bus.wb_data);
    sel2_s      = select_operand(bus.src2_reg, bus.bitline2, bus.wb_we, bus.wb_reg, bus.wb_data);
    refresh1_s  = stalled_s && bus.wb_we && (bus.wb_reg != {AW{1'b0}}) && (bus.wb_reg == op_src1_r);
    refresh2_s  = stalled_s && bus.wb_we && (bus.wb_reg != {AW{1'b0}}) && (bus.wb_reg == op_src2_r);
  end

  // One-hot read enables, all-zero when decode presents nothing.
  always_comb begin
    ren1_s = {NREG{1'b0}};
    ren2_s = {NREG{1'b0}};
    if (bus.src_valid) begin
      ren1_s[bus.src1_reg] = 1'b1;
      ren2_s[bus.src2_reg] = 1'b1;
    end else begin
      ren1_s = {NREG{1'b0}};
      ren2_s = {NREG{1'b0}};
    end
  end

  // Valid flag and captured specifiers; flush outranks capture and drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_valid_r <= 1'b0;
      op_src1_r  <= {AW{1'b0}};
      op_src2_r  <= {AW{1'b0}};
    end else if (bus.flush) begin
      op_valid_r <= 1'b0;
    end else if (capture_s) begin
      op_valid_r <= 1'b1;
      op_src1_r  <= bus.src1_reg;
      op_src2_r  <= bus.src2_reg;
    end else if (op_valid_r && bus.ex_ready) begin
      op_valid_r <= 1'b0;
    end else begin
      op_valid_r <= op_valid_r;
    end
  end

  // Operand 1 data: capture, or refresh from write-back while held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op1_r <= {DW{1'b0}};
    end else if (capture_s) begin
      op1_r <= sel1_s;
    end else if (refresh1_s) begin
      op1_r <= bus.wb_data;
    end else begin
      op1_r <= op1_r;
    end
  end

  // Operand 2 data: capture, or refresh from write-back while held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op2_r <= {DW{1'b0}};
    end else if (capture_s) begin
      op2_r <= sel2_s;
    end else if (refresh2_s) begin
      op2_r <= bus.wb_data;
    end else begin
      op2_r <= op2_r;
    end
  end

  // Saturating count of stalled cycles; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CW{1'b0}};
    end else if (stalled_s && !bus.flush && (stall_cnt_r != STALL_MAX)) begin
      stall_cnt_r <= stall_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.src_ready = src_ready_s;
  assign bus.ren1      = ren1_s;
  assign bus.ren2      = ren2_s;
  assign bus.op_valid  = op_valid_r;
  assign bus.op1       = op1_r;
  assign bus.op2       = op2_r;
  assign bus.op_src1   = op_src1_r;
  assign bus.op_src2   = op_src2_r;
  assign bus.stall_cnt = stall_cnt_r;
endmodule
